intensity_color_ctrl: RTL

- Upstream control stage for the PWM intensity drivers.
- Takes three raw push-buttons (up, down, colour) and maintains a saturating brightness level from 0 to MAX_DUTY. It also maintains a 3-bit colour code.
- Drives three 8-bit duty-cycle outputs, one per RGB PWM instance. The PWM instances count 0..100, so the duty values are in percent.

---
 rtl/intensity_color_ctrl_pkg.sv | 23 ++
 rtl/intensity_color_ctrl_btn_debounce.sv | 52 +++++
 rtl/intensity_color_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/intensity_color_ctrl_pkg.sv
// Shared constants for the intensity/colour control block: colour bit positions,
// named colour codes and default tuning values.
package intensity_color_ctrl_pkg;

    localparam int COLOR_R_BIT = 2;
    localparam int COLOR_G_BIT = 1;
    localparam int COLOR_B_BIT = 0;

    typedef logic [2:0] color_t;
    typedef logic [7:0] duty_t;

    localparam color_t COLOR_OFF   = 3'd0;
    localparam color_t COLOR_BLUE  = 3'd1;
    localparam color_t COLOR_GREEN = 3'd2;
    localparam color_t COLOR_RED   = 3'd4;
    localparam color_t COLOR_WHITE = 3'd7;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_STEP            = 10;
    localparam int DEF_MAX_DUTY        = 100;
    localparam int DEF_RESET_LEVEL     = 50;

endpackage

// File: rtl/intensity_color_ctrl_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-run debounce counter,
// debounced level and a one-cycle pulse on each accepted press (releases are silent).
import intensity_color_ctrl_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            // Any edge where input agrees with the debounced state restarts the run.
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btn_level = r_deb;
    assign btn_press = r_deb & ~r_deb_q;

endmodule

// File: rtl/intensity_color_ctrl.sv
// Button-driven brightness level (saturating 0..MAX_DUTY) and 3-bit colour code,
// fanned out as registered per-channel duty values one cycle after level/colour.
import intensity_color_ctrl_pkg::*;

module intensity_color_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP            = DEF_STEP,
    parameter int MAX_DUTY        = DEF_MAX_DUTY,
    parameter int RESET_LEVEL     = DEF_RESET_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_color,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic [7:0] level,
    output logic [2:0] color_idx
);

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] MAX9  = 9'(MAX_DUTY);
    localparam duty_t      STEP8 = 8'(STEP);
    localparam duty_t      MAX8  = 8'(MAX_DUTY);
    localparam duty_t      RST8  = 8'(RESET_LEVEL);

    logic       w_up;
    logic       w_dn;
    logic       w_col;
    logic [2:0] w_unused_btn_level;
    logic [8:0] w_sum;
    duty_t      w_level_nxt;

    duty_t  r_level;
    color_t r_color;
    duty_t  r_duty_r;
    duty_t  r_duty_g;
    duty_t  r_duty_b;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn_raw(btn_up),
        .btn_level(w_unused_btn_level[0]), .btn_press(w_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn_raw(btn_down),
        .btn_level(w_unused_btn_level[1]), .btn_press(w_dn)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_color (
        .clk(clk), .reset(reset), .btn_raw(btn_color),
        .btn_level(w_unused_btn_level[2]), .btn_press(w_col)
    );

    // Sum kept at 9 bits so a near-255 limit cannot wrap before the clamp.
    assign w_sum = {1'b0, r_level} + STEP9;

    always_comb begin
        w_level_nxt = r_level;
        if (w_up && !w_dn) begin
            w_level_nxt = (w_sum > MAX9) ? MAX8 : w_sum[7:0];
        end else if (w_dn && !w_up) begin
            w_level_nxt = (r_level < STEP8) ? 8'd0 : r_level - STEP8;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level  <= RST8;
            r_color  <= COLOR_WHITE;
            r_duty_r <= RST8;
            r_duty_g <= RST8;
            r_duty_b <= RST8;
        end else begin
            r_level <= w_level_nxt;
            if (w_col) begin
                r_color <= r_color + 3'd1;
            end
            r_duty_r <= r_color[COLOR_R_BIT] ? r_level : 8'd0;
            r_duty_g <= r_color[COLOR_G_BIT] ? r_level : 8'd0;
            r_duty_b <= r_color[COLOR_B_BIT] ? r_level : 8'd0;
        end
    end

    assign level     = r_level;
    assign color_idx = r_color;
    assign duty_r    = r_duty_r;
    assign duty_g    = r_duty_g;
    assign duty_b    = r_duty_b;

endmodule
